// File: rtl/tx_iq_fifo_ctrl_pkg.sv
// Shared sizes, byte ordering and assembler state encoding for the Tx IQ FIFO reader.
package tx_iq_fifo_ctrl_pkg;

  localparam int IQ_BYTES       = 6;
  localparam int SAMPLE_W       = 24;
  localparam int CNT_W          = 16;
  localparam int IQ_W           = IQ_BYTES * 8;
  localparam int BYTES_PER_WORD = SAMPLE_W / 8;

  // Position of the first (most significant) byte of each word in the stream.
  localparam int BYTE_I_HI = 0;
  localparam int BYTE_Q_HI = 3;

  localparam logic [2:0] IQ_BYTES_C = 3'(IQ_BYTES);

  typedef enum logic {
    ASM_FILL     = 1'b0,
    ASM_COMPLETE = 1'b1
  } asm_state_e;

  // The assembly register is shifted MSB first, so byte 0 ends up in the top bits.
  function automatic logic [SAMPLE_W-1:0] iq_word(input logic [IQ_W-1:0] s, input int first_byte);
    return s[(IQ_BYTES - first_byte - BYTES_PER_WORD) * 8 +: SAMPLE_W];
  endfunction

endpackage

// File: rtl/tx_iq_fifo_ctrl_if.sv
// FIFO read side and DUC sample side of the Tx IQ FIFO reader.
interface tx_iq_fifo_ctrl_if;
  import tx_iq_fifo_ctrl_pkg::*;

  logic [7:0]          fifo_q;
  logic                fifo_empty;
  logic                fifo_rdreq;
  logic                flush;
  logic                sample_strobe;
  logic [SAMPLE_W-1:0] tx_I;
  logic [SAMPLE_W-1:0] tx_Q;
  logic                tx_valid;
  logic                underrun;
  logic [CNT_W-1:0]    underrun_cnt;

  modport slave (
    input  fifo_q, fifo_empty, flush, sample_strobe,
    output fifo_rdreq, tx_I, tx_Q, tx_valid, underrun, underrun_cnt
  );

  modport master (
    output fifo_q, fifo_empty, flush, sample_strobe,
    input  fifo_rdreq, tx_I, tx_Q, tx_valid, underrun, underrun_cnt
  );

endinterface

// File: rtl/tx_iq_fifo_ctrl_iq_byte_assembler.sv
// Issues FIFO reads and shifts six landed bytes into one 48-bit {I,Q} word.
//   state        | meaning
//   ASM_FILL     | issuing reads / landing bytes for the next sample
//   ASM_COMPLETE | six bytes landed, waiting for the hold register to take them
module iq_byte_assembler
  import tx_iq_fifo_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            fifo_empty_i,
  input  logic [7:0]      fifo_q_i,
  input  logic            consume_i,
  output logic            fifo_rdreq_o,
  output logic            complete_o,
  output logic [IQ_W-1:0] sample_o
);

  asm_state_e      state_q, state_d;
  logic [2:0]      issued_q, issued_d;
  logic [2:0]      landed_q, landed_d;
  logic            rd_pend_q, rd_pend_d;
  logic [IQ_W-1:0] shift_q, shift_d;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ASM_FILL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ASM_FILL;
    end else begin
      case (state_q)
        ASM_FILL:     if (rd_pend_q && landed_q == IQ_BYTES_C - 3'd1) state_d = ASM_COMPLETE;
        ASM_COMPLETE: if (consume_i) state_d = ASM_FILL;
        default:      state_d = ASM_FILL;
      endcase
    end
  end

  always_comb begin
    fifo_rdreq_o = 1'b0;
    complete_o   = 1'b0;
    case (state_q)
      ASM_FILL:     fifo_rdreq_o = !fifo_empty_i && (issued_q < IQ_BYTES_C) && !flush_i && !reset;
      ASM_COMPLETE: complete_o   = 1'b1;
      default:      ;
    endcase
  end

  // A byte still in flight when flush hits is dropped via rd_pend.
  always_comb begin
    issued_d  = issued_q;
    landed_d  = landed_q;
    rd_pend_d = fifo_rdreq_o;
    shift_d   = shift_q;
    if (flush_i) begin
      issued_d  = '0;
      landed_d  = '0;
      rd_pend_d = 1'b0;
      shift_d   = '0;
    end else if (consume_i) begin
      issued_d = '0;
      landed_d = '0;
    end else begin
      if (fifo_rdreq_o) issued_d = issued_q + 3'd1;
      if (rd_pend_q) begin
        landed_d = landed_q + 3'd1;
        shift_d  = {shift_q[IQ_W-9:0], fifo_q_i};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      issued_q  <= '0;
      landed_q  <= '0;
      rd_pend_q <= 1'b0;
      shift_q   <= '0;
    end else begin
      issued_q  <= issued_d;
      landed_q  <= landed_d;
      rd_pend_q <= rd_pend_d;
      shift_q   <= shift_d;
    end
  end

  assign sample_o = shift_q;

endmodule

// File: rtl/tx_iq_fifo_ctrl.sv
// Rebuilds 24-bit I/Q samples from the Tx byte FIFO and hands one held sample
// to the DUC on each sample strobe, zero-filling (or repeating) on underrun.
module tx_iq_fifo_ctrl
  import tx_iq_fifo_ctrl_pkg::*;
#(
  parameter int RD_LATENCY       = 1,
  parameter bit ZERO_ON_UNDERRUN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  tx_iq_fifo_ctrl_if.slave bus
);

  if (RD_LATENCY != 1) begin : g_bad_rd_latency
    $error("tx_iq_fifo_ctrl: only RD_LATENCY=1 is supported");
  end

  logic            fifo_rdreq;
  logic            asm_complete;
  logic [IQ_W-1:0] asm_sample;
  logic            strobe_hit;
  logic            transfer;

  logic [IQ_W-1:0]     hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [SAMPLE_W-1:0] tx_I_q, tx_I_d;
  logic [SAMPLE_W-1:0] tx_Q_q, tx_Q_d;
  logic                tx_valid_q, tx_valid_d;
  logic                underrun_q, underrun_d;
  logic [CNT_W-1:0]    underrun_cnt_q, underrun_cnt_d;

  iq_byte_assembler u_asm (
    .clock        (clock),
    .reset        (reset),
    .flush_i      (bus.flush),
    .fifo_empty_i (bus.fifo_empty),
    .fifo_q_i     (bus.fifo_q),
    .consume_i    (transfer),
    .fifo_rdreq_o (fifo_rdreq),
    .complete_o   (asm_complete),
    .sample_o     (asm_sample)
  );

  // The strobe only sees the registered hold_full, so a sample arriving in the
  // strobe cycle waits for the next strobe.
  always_comb begin
    strobe_hit  = bus.sample_strobe && hold_full_q && !bus.flush;
    transfer    = asm_complete && !bus.flush && (!hold_full_q || strobe_hit);
    hold_d      = transfer ? asm_sample : hold_q;
    hold_full_d = hold_full_q;
    if (bus.flush)      hold_full_d = 1'b0;
    else if (transfer)  hold_full_d = 1'b1;
    else if (strobe_hit) hold_full_d = 1'b0;
  end

  always_comb begin
    tx_valid_d     = bus.sample_strobe;
    underrun_d     = bus.sample_strobe && !strobe_hit;
    tx_I_d         = tx_I_q;
    tx_Q_d         = tx_Q_q;
    underrun_cnt_d = underrun_cnt_q;
    if (strobe_hit) begin
      tx_I_d = iq_word(hold_q, BYTE_I_HI);
      tx_Q_d = iq_word(hold_q, BYTE_Q_HI);
    end else if (underrun_d && ZERO_ON_UNDERRUN) begin
      tx_I_d = '0;
      tx_Q_d = '0;
    end
    if (underrun_d && underrun_cnt_q != '1) underrun_cnt_d = underrun_cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q         <= '0;
      hold_full_q    <= 1'b0;
      tx_I_q         <= '0;
      tx_Q_q         <= '0;
      tx_valid_q     <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      hold_q         <= hold_d;
      hold_full_q    <= hold_full_d;
      tx_I_q         <= tx_I_d;
      tx_Q_q         <= tx_Q_d;
      tx_valid_q     <= tx_valid_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign bus.fifo_rdreq   = fifo_rdreq;
  assign bus.tx_I         = tx_I_q;
  assign bus.tx_Q         = tx_Q_q;
  assign bus.tx_valid     = tx_valid_q;
  assign bus.underrun     = underrun_q;
  assign bus.underrun_cnt = underrun_cnt_q;

endmodule
